// File: rtl/mcu_command_decoder.sv
// Byte-level MCU command decoder: parses SPI transactions (NOP/WRITE/READ/STATUS),
// owns the renderer configuration register file and produces per-byte response bytes.
module mcu_command_decoder #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned DATA_BYTES = 2,
  parameter logic [3:0]  STATUS_ID  = 4'hA
) (
  input  logic                               i_master_clk,
  input  logic                               i_reset_n,
  input  logic [7:0]                         i_master_data,
  input  logic                               i_master_data_valid,
  input  logic                               i_master_start,
  input  logic                               i_master_end,
  output logic [7:0]                         o_response_data,
  output logic                               o_response_data_valid,
  output logic                               o_reg_write,
  output logic [5:0]                         o_reg_addr,
  output logic [DATA_BYTES*8-1:0]            o_reg_data,
  output logic [NUM_REGS*DATA_BYTES*8-1:0]   o_regs,
  output logic                               o_error
);

  localparam int unsigned DW = DATA_BYTES * 8;
  localparam int unsigned RW = NUM_REGS * DW;
  localparam logic [1:0]  LAST_IDX = 2'(DATA_BYTES - 1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DISCARD} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_WRITE, OP_READ, OP_STATUS} op_t;

  state_t          state_q, state_d;
  logic [5:0]      addr_q, addr_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   wbuf_q, wbuf_d;
  logic [RW-1:0]   regs_q, regs_d;
  logic            err_q, err_d;
  logic [7:0]      resp_q, resp_d;
  logic            resp_v_q, resp_v_d;
  logic            wr_q, wr_d;
  logic [5:0]      wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;

  function automatic logic addr_ok(input logic [5:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  function automatic logic [DW-1:0] reg_value(input logic [RW-1:0] rf, input logic [5:0] a);
    logic [DW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (32'(a) == i) v = rf[i*DW +: DW];
    return v;
  endfunction

  // Byte k of a register value, k=0 being the most significant byte
  function automatic logic [7:0] value_byte(input logic [DW-1:0] v, input logic [1:0] k);
    logic [7:0] b;
    b = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++)
      if (32'(k) == i) b = v[DW-1-8*i -: 8];
    return b;
  endfunction

  state_t          eff_state;
  logic            err_set, err_clr;
  op_t             op;
  logic [DW-1:0]   wbuf_next;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    wbuf_d    = wbuf_q;
    regs_d    = regs_q;
    resp_d    = '0;
    resp_v_d  = 1'b0;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    op        = op_t'(i_master_data[7:6]);
    wbuf_next = (wbuf_q << 8) | DW'(i_master_data);

    // Start is handled before a same-cycle byte, so that byte becomes the command byte
    eff_state = i_master_start ? CMD : state_q;
    if (i_master_start) begin
      state_d = CMD;
      if (state_q == WDATA) err_set = 1'b1;
    end

    if (i_master_data_valid && eff_state != IDLE) begin
      resp_v_d = 1'b1;
      unique case (eff_state)
        CMD: begin
          addr_d = i_master_data[5:0];
          idx_d  = '0;
          wbuf_d = '0;
          unique case (op)
            OP_WRITE: begin
              state_d = WDATA;
              if (!addr_ok(i_master_data[5:0])) err_set = 1'b1;
            end
            OP_READ: begin
              state_d = RDATA;
              if (addr_ok(i_master_data[5:0]))
                resp_d = value_byte(reg_value(regs_q, i_master_data[5:0]), 2'd0);
              else
                err_set = 1'b1;
            end
            OP_STATUS: begin
              state_d = DISCARD;
              resp_d  = {err_q, 3'b000, STATUS_ID};
              err_clr = 1'b1;
            end
            default: state_d = DISCARD;
          endcase
        end
        WDATA: begin
          wbuf_d = wbuf_next;
          idx_d  = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            state_d = DISCARD;
            if (addr_ok(addr_q)) begin
              wr_d      = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = wbuf_next;
              for (int unsigned i = 0; i < NUM_REGS; i++)
                if (32'(addr_q) == i) regs_d[i*DW +: DW] = wbuf_next;
            end
          end
        end
        RDATA: begin
          idx_d = idx_q + 2'd1;
          if (idx_q == LAST_IDX)
            state_d = DISCARD;
          else if (addr_ok(addr_q))
            resp_d = value_byte(reg_value(regs_q, addr_q), idx_q + 2'd1);
        end
        default: ;
      endcase
    end

    // A write still waiting for data when CS is released is truncated
    if (i_master_end) begin
      if (state_d == WDATA) err_set = 1'b1;
      state_d = IDLE;
    end

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge i_master_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      wbuf_q    <= '0;
      regs_q    <= '0;
      err_q     <= 1'b0;
      resp_q    <= '0;
      resp_v_q  <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      wbuf_q    <= wbuf_d;
      regs_q    <= regs_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      resp_v_q  <= resp_v_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_response_data       = resp_q;
  assign o_response_data_valid = resp_v_q;
  assign o_reg_write           = wr_q;
  assign o_reg_addr            = wr_addr_q;
  assign o_reg_data            = wr_data_q;
  assign o_regs                = regs_q;
  assign o_error               = err_q;

endmodule

// File: tb/tb_mcu_command_decoder.sv
// Bench for mcu_command_decoder: directed vector table, randomized traffic against a
// transaction-level reference model, and a mid-write reset sequence.
module tb_mcu_command_decoder;

  localparam int unsigned NR = 8;
  localparam int unsigned DB = 2;

  logic         clk = 1'b0;
  logic         rst_n, st, dv, en;
  logic [7:0]   d;
  logic [7:0]   resp;
  logic         resp_v, wr, err;
  logic [5:0]   wa;
  logic [15:0]  wd;
  logic [127:0] regs;

  always #5 clk = ~clk;

  mcu_command_decoder #(.NUM_REGS(NR), .DATA_BYTES(DB), .STATUS_ID(4'hA)) dut (
    .i_master_clk(clk), .i_reset_n(rst_n),
    .i_master_data(d), .i_master_data_valid(dv),
    .i_master_start(st), .i_master_end(en),
    .o_response_data(resp), .o_response_data_valid(resp_v),
    .o_reg_write(wr), .o_reg_addr(wa), .o_reg_data(wd),
    .o_regs(regs), .o_error(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic s, input logic v, input logic [7:0] b, input logic e);
    @(negedge clk);
    st = s; dv = v; d = b; en = e;
    @(posedge clk);
    #1;
    st = 1'b0; dv = 1'b0; d = 8'h00; en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Directed vectors: one row per clock, expectations observed just after that edge
  typedef struct {
    logic        s, v;
    logic [7:0]  b;
    logic        e;
    logic        ev;
    logic [7:0]  er;
    logic        ew;
    logic [5:0]  ewa;
    logic [15:0] ewd;
    logic        ee;
    int          rs;
    logic [15:0] rv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic s, v, input logic [7:0] b, input logic e,
                               input logic ev, input logic [7:0] er,
                               input logic ew, input logic [5:0] ewa, input logic [15:0] ewd,
                               input logic ee, input int rs, input logic [15:0] rv);
    vec_t r;
    r.s = s; r.v = v; r.b = b; r.e = e; r.ev = ev; r.er = er;
    r.ew = ew; r.ewa = ewa; r.ewd = ewd; r.ee = ee; r.rs = rs; r.rv = rv;
    return r;
  endfunction

  // Reference model: tracks byte position inside the current transaction
  bit          m_in;
  int          m_n;
  logic [1:0]  m_op;
  logic [5:0]  m_addr;
  int unsigned m_wbuf;
  logic [15:0] m_reg[NR];
  bit          m_err;
  logic        e_rv, e_wr;
  logic [7:0]  e_resp;
  logic [5:0]  e_wa;
  logic [15:0] e_wd;

  function automatic logic [7:0] reg_byte(input logic [15:0] v, input int k);
    logic [15:0] t;
    t = v >> (8 * (int'(DB) - 1 - k));
    return t[7:0];
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < int'(NR); i++) f[i*16 +: 16] = m_reg[i];
    return f;
  endfunction

  task automatic model_reset();
    m_in = 0; m_n = 0; m_op = 0; m_addr = 0; m_wbuf = 0; m_err = 0;
    for (int i = 0; i < int'(NR); i++) m_reg[i] = '0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [7:0] b, input logic e);
    bit set, clr, ok;
    set = 0; clr = 0;
    e_rv = 0; e_resp = 8'h00; e_wr = 0;
    if (s) begin
      if (m_in && m_op == 2'b01 && m_n >= 1 && m_n <= int'(DB)) set = 1;
      m_in = 1; m_n = 0;
    end
    if (v && m_in) begin
      e_rv = 1;
      if (m_n == 0) begin
        m_op = b[7:6]; m_addr = b[5:0]; m_wbuf = 0;
        ok = int'(m_addr) < int'(NR);
        case (m_op)
          2'b01: if (!ok) set = 1;
          2'b10: if (!ok) set = 1; else e_resp = reg_byte(m_reg[m_addr[2:0]], 0);
          2'b11: begin e_resp = {m_err, 3'b000, 4'hA}; clr = 1; end
          default: ;
        endcase
      end else begin
        ok = int'(m_addr) < int'(NR);
        if (m_op == 2'b01 && m_n <= int'(DB)) begin
          m_wbuf = ((m_wbuf << 8) | b) & 32'hFFFF;
          if (m_n == int'(DB) && ok) begin
            e_wr = 1; e_wa = m_addr; e_wd = m_wbuf[15:0];
            m_reg[m_addr[2:0]] = m_wbuf[15:0];
          end
        end
        if (m_op == 2'b10 && m_n < int'(DB) && ok) e_resp = reg_byte(m_reg[m_addr[2:0]], m_n);
      end
      if (m_n < 100) m_n++;
    end
    if (e) begin
      if (m_in && m_op == 2'b01 && m_n >= 1 && m_n <= int'(DB)) set = 1;
      m_in = 0;
    end
    if (set) m_err = 1; else if (clr) m_err = 0;
  endtask

  initial begin
    logic [127:0] snap;
    logic         rs, rv, re;
    logic [7:0]   rb;
    rst_n = 1'b0; st = 0; dv = 0; en = 0; d = 8'h00;

    // write reg3, stray idle byte, read back, truncated write, status
    tbl.push_back(row(1,0,8'h00,0, 0,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h43,0, 1,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h12,0, 1,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h34,0, 1,8'h00, 1,3,16'h1234,0, 3,16'h1234));
    tbl.push_back(row(0,0,8'h00,1, 0,8'h00, 0,0,0,      0, 3,16'h1234));
    tbl.push_back(row(0,1,8'h55,0, 0,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(1,0,8'h00,0, 0,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h83,0, 1,8'h12, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h00,0, 1,8'h34, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h00,0, 1,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,0,8'h00,1, 0,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(1,0,8'h00,0, 0,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h45,0, 1,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'hAA,0, 1,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,0,8'h00,1, 0,8'h00, 0,0,0,      1, 5,16'h0000));
    tbl.push_back(row(1,0,8'h00,0, 0,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,1,8'hC0,0, 1,8'h8A, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h00,0, 1,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,0,8'h00,1, 0,8'h00, 0,0,0,      0, 5,16'h0000));
    // out-of-range write and read, then status clears the error
    tbl.push_back(row(1,0,8'h00,0, 0,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'h7F,0, 1,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,1,8'h01,0, 1,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,1,8'h02,0, 1,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,0,8'h00,1, 0,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(1,0,8'h00,0, 0,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,1,8'hBF,0, 1,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,1,8'h00,0, 1,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,1,8'h00,0, 1,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,0,8'h00,1, 0,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(1,0,8'h00,0, 0,8'h00, 0,0,0,      1, -1,0));
    tbl.push_back(row(0,1,8'hC0,0, 1,8'h8A, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,0,8'h00,1, 0,8'h00, 0,0,0,      0, -1,0));
    // start and command byte in the same cycle
    tbl.push_back(row(1,1,8'h41,0, 1,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'hBE,0, 1,8'h00, 0,0,0,      0, -1,0));
    tbl.push_back(row(0,1,8'hEF,0, 1,8'h00, 1,1,16'hBEEF,0, 1,16'hBEEF));
    tbl.push_back(row(0,0,8'h00,1, 0,8'h00, 0,0,0,      0, 3,16'h1234));

    do_reset();
    check("reset_resp_v", resp_v, 1'b0);
    check("reset_wr", wr, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_regs", regs, '0);
    check("reset_wa_wd", {wa, wd}, '0);

    foreach (tbl[i]) begin
      cycle(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].e);
      check($sformatf("vec%0d_resp_v", i), resp_v, tbl[i].ev);
      if (tbl[i].ev) check($sformatf("vec%0d_resp", i), resp, tbl[i].er);
      check($sformatf("vec%0d_wr", i), wr, tbl[i].ew);
      if (tbl[i].ew) check($sformatf("vec%0d_waddr_wdata", i), {wa, wd}, {tbl[i].ewa, tbl[i].ewd});
      check($sformatf("vec%0d_err", i), err, tbl[i].ee);
      if (tbl[i].rs >= 0) begin
        snap = regs;
        check($sformatf("vec%0d_reg%0d", i, tbl[i].rs), snap[tbl[i].rs*16 +: 16], tbl[i].rv);
      end
    end

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      rs = ($urandom_range(0, 9) == 0);
      re = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 1) == 1);
      rb = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 9))};
      if ($urandom_range(0, 15) == 0) rb[5:0] = 6'h3F;
      model_step(rs, rv, rb, re);
      cycle(rs, rv, rb, re);
      check("rnd_resp_v", resp_v, e_rv);
      if (e_rv) check("rnd_resp", resp, e_resp);
      check("rnd_wr", wr, e_wr);
      if (e_wr) check("rnd_waddr_wdata", {wa, wd}, {e_wa, e_wd});
      check("rnd_err", err, m_err);
      check("rnd_regs", regs, model_flat());
    end

    // reset in the middle of a write
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h42, 0);
    cycle(0, 1, 8'hAB, 0);
    cycle(0, 1, 8'hCD, 0);
    cycle(0, 0, 8'h00, 1);
    snap = regs;
    check("pre_reset_reg2", snap[2*16 +: 16], 16'hABCD);
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h46, 0);
    cycle(0, 1, 8'h11, 0);
    @(negedge clk);
    rst_n = 1'b0; dv = 1'b1; d = 8'h22;
    @(posedge clk);
    #1;
    dv = 1'b0; d = 8'h00; rst_n = 1'b1;
    check("midwr_reset_regs", regs, '0);
    check("midwr_reset_wr", wr, 1'b0);
    check("midwr_reset_resp_v", resp_v, 1'b0);
    check("midwr_reset_err", err, 1'b0);
    cycle(0, 1, 8'h33, 0);
    check("post_reset_idle_byte", resp_v, 1'b0);
    check("post_reset_no_commit", wr, 1'b0);
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h86, 0);
    check("post_reset_read_v", resp_v, 1'b1);
    check("post_reset_read_d", resp, 8'h00);
    cycle(0, 0, 8'h00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
